// File: rtl/zigzag_pkg.sv
// Shared types and defaults for the zig-zag bit-plane address generator.
package zigzag_pkg;

    localparam int ZZ_BPREC = 4;   // default precision/offset width
    localparam int ZZ_BCNT  = 16;  // default pass-repeat count width
    // Coordinate arithmetic width; holds pw+pd-1 for any BPREC up to 7.
    localparam int ZZ_CW    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } zz_state_t;

    // Current position of the walk: weight plane, data plane, diagonal index.
    typedef struct packed {
        logic [ZZ_CW-1:0] iw;
        logic [ZZ_CW-1:0] id;
        logic [ZZ_CW-1:0] k;
    } zz_coord_t;

endpackage

// File: rtl/zigzag_next.sv
// Combinational successor of a zig-zag coordinate plus the flags of the successor.
// A coordinate that ends its pass wraps to the first element of the walk, which
// lets the same logic produce the load value when seeded with the pass-final element.
module zigzag_next
    import zigzag_pkg::*;
(
    input  zz_coord_t        cur_i,
    input  logic [ZZ_CW-1:0] pw_i,        // effective precision, >= 1
    input  logic [ZZ_CW-1:0] pd_i,        // effective precision, >= 1
    input  logic             msb_first_i,
    output zz_coord_t        nxt_o,
    output logic             sh_o,        // successor ends its diagonal
    output logic             plast_o      // successor ends its pass
);

    localparam logic [ZZ_CW-1:0] ONE = ZZ_CW'(1);
    localparam logic [ZZ_CW-1:0] TWO = ZZ_CW'(2);

    logic [ZZ_CW-1:0] pwm1, pdm1, kmax, k_beg, k_end;
    logic             cur_sh, cur_pl;

    // Step along the diagonal, or jump to the head of the next diagonal in walk order.
    always_comb begin
        pwm1   = pw_i - ONE;
        pdm1   = pd_i - ONE;
        kmax   = pw_i + pd_i - TWO;
        k_beg  = msb_first_i ? kmax : '0;
        k_end  = msb_first_i ? '0 : kmax;
        cur_sh = (cur_i.iw == '0) || (cur_i.id == pdm1);
        cur_pl = cur_sh && (cur_i.k == k_end);

        nxt_o = cur_i;
        if (!cur_sh) begin
            nxt_o.iw = cur_i.iw - ONE;
            nxt_o.id = cur_i.id + ONE;
        end else begin
            if (cur_pl)
                nxt_o.k = k_beg;
            else if (msb_first_i)
                nxt_o.k = cur_i.k - ONE;
            else
                nxt_o.k = cur_i.k + ONE;
            nxt_o.iw = (nxt_o.k > pwm1) ? pwm1 : nxt_o.k;
            nxt_o.id = nxt_o.k - nxt_o.iw;
        end

        sh_o    = (nxt_o.iw == '0) || (nxt_o.id == pdm1);
        plast_o = sh_o && (nxt_o.k == k_end);
    end

endmodule

// File: rtl/zigzag_agu.sv
// Zig-zag bit-plane pair address generator with start/done control and
// valid/ready output handshake. All outputs come straight from registers.
module zigzag_agu
    import zigzag_pkg::*;
#(
    parameter int BPREC = ZZ_BPREC,
    parameter int BCNT  = ZZ_BCNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BPREC-1:0] pw,
    input  logic [BPREC-1:0] pd,
    input  logic [BCNT-1:0]  nrep,
    input  logic             msb_first,
    output logic             busy,
    output logic             done,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [BPREC-1:0] offw,
    output logic [BPREC-1:0] offd,
    output logic             o_sh,
    output logic             o_plast,
    output logic             o_last
);

    localparam logic [ZZ_CW-1:0] ONE = ZZ_CW'(1);
    localparam logic [ZZ_CW-1:0] TWO = ZZ_CW'(2);

    zz_state_t        state_q;
    zz_coord_t        coord_q;
    logic [ZZ_CW-1:0] pw_q, pd_q;
    logic [BCNT-1:0]  nrep_m1_q, pass_q, pass_d;
    logic             msb_q, sh_q, plast_q, last_q, busy_q, done_q, valid_q;

    // Configuration as presented on the inputs, with zero precisions/counts bumped to 1.
    logic [ZZ_CW-1:0] pw_in, pd_in, kmax_in;
    logic [BCNT-1:0]  nrep_in;
    zz_coord_t        seed;

    // Seed is the final element of a pass so that its successor is the first element.
    always_comb begin
        pw_in   = (pw == '0) ? ONE : ZZ_CW'(pw);
        pd_in   = (pd == '0) ? ONE : ZZ_CW'(pd);
        nrep_in = (nrep == '0) ? BCNT'(1) : nrep;
        kmax_in = pw_in + pd_in - TWO;
        seed.k  = msb_first ? '0 : kmax_in;
        seed.iw = msb_first ? '0 : pw_in - ONE;
        seed.id = msb_first ? '0 : pd_in - ONE;
    end

    zz_coord_t ld_nxt, adv_nxt;
    logic      ld_sh, ld_plast, adv_sh, adv_plast;

    zigzag_next u_ld (
        .cur_i       (seed),
        .pw_i        (pw_in),
        .pd_i        (pd_in),
        .msb_first_i (msb_first),
        .nxt_o       (ld_nxt),
        .sh_o        (ld_sh),
        .plast_o     (ld_plast)
    );

    zigzag_next u_adv (
        .cur_i       (coord_q),
        .pw_i        (pw_q),
        .pd_i        (pd_q),
        .msb_first_i (msb_q),
        .nxt_o       (adv_nxt),
        .sh_o        (adv_sh),
        .plast_o     (adv_plast)
    );

    // Pass count after accepting the current element.
    always_comb begin
        pass_d = plast_q ? pass_q + BCNT'(1) : pass_q;
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            coord_q   <= '0;
            pw_q      <= '0;
            pd_q      <= '0;
            nrep_m1_q <= '0;
            pass_q    <= '0;
            msb_q     <= 1'b0;
            sh_q      <= 1'b0;
            plast_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        pw_q      <= pw_in;
                        pd_q      <= pd_in;
                        nrep_m1_q <= nrep_in - BCNT'(1);
                        msb_q     <= msb_first;
                        pass_q    <= '0;
                        coord_q   <= ld_nxt;
                        sh_q      <= ld_sh;
                        plast_q   <= ld_plast;
                        last_q    <= ld_plast && (nrep_in == BCNT'(1));
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (o_ready) begin
                        if (last_q) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            sh_q    <= 1'b0;
                            plast_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            coord_q <= adv_nxt;
                            sh_q    <= adv_sh;
                            plast_q <= adv_plast;
                            pass_q  <= pass_d;
                            last_q  <= adv_plast && (pass_d == nrep_m1_q);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign o_valid = valid_q;
    assign offw    = coord_q.iw[BPREC-1:0];
    assign offd    = coord_q.id[BPREC-1:0];
    assign o_sh    = sh_q;
    assign o_plast = plast_q;
    assign o_last  = last_q;

    // Offsets never exceed BPREC bits; the upper coordinate bits only serve the arithmetic.
    logic unused_coord_hi;
    assign unused_coord_hi = ^{coord_q.iw[ZZ_CW-1:BPREC], coord_q.id[ZZ_CW-1:BPREC]};

endmodule

// File: tb/tb_zigzag_agu.sv
// Directed bench for zigzag_agu with a scoreboard queue and a decoupled monitor.
module tb_zigzag_agu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  pw = '0, pd = '0;
    logic [15:0] nrep = '0;
    logic        msb_first = 1'b0;
    logic        o_ready = 1'b0;
    logic        busy, done, o_valid, o_sh, o_plast, o_last;
    logic [3:0]  offw, offd;

    zigzag_agu #(.BPREC(4), .BCNT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pw(pw), .pd(pd), .nrep(nrep),
        .msb_first(msb_first), .busy(busy), .done(done), .o_valid(o_valid),
        .o_ready(o_ready), .offw(offw), .offd(offd), .o_sh(o_sh),
        .o_plast(o_plast), .o_last(o_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int iw;
        int id;
        bit sh;
        bit plast;
        bit last;
    } el_t;

    el_t expq[$];
    el_t logq[$];
    int  vectors = 0;
    int  errors  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference walk: enumerate each diagonal from its top weight plane downward.
    task automatic gen(input int p_w, input int p_d, input int n, input bit msb);
        int pe, de, ne, kk, hi, lo, nd;
        pe = (p_w == 0) ? 1 : p_w;
        de = (p_d == 0) ? 1 : p_d;
        ne = (n == 0) ? 1 : n;
        nd = pe + de - 1;
        for (int r = 0; r < ne; r++)
            for (int j = 0; j < nd; j++) begin
                kk = msb ? nd - 1 - j : j;
                hi = (kk < pe - 1) ? kk : pe - 1;
                lo = (kk - de + 1 > 0) ? kk - de + 1 : 0;
                for (int w = hi; w >= lo; w--) begin
                    el_t e;
                    e.iw    = w;
                    e.id    = kk - w;
                    e.sh    = (w == lo);
                    e.plast = e.sh && (j == nd - 1);
                    e.last  = e.plast && (r == ne - 1);
                    expq.push_back(e);
                end
            end
    endtask

    // Monitor: every valid cycle must show the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        el_t e, a;
        if (rst_n && o_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected element", 1, 0);
            end else begin
                e = expq[0];
                chk("offw", int'(offw), e.iw);
                chk("offd", int'(offd), e.id);
                chk("o_sh", int'(o_sh), int'(e.sh));
                chk("o_plast", int'(o_plast), int'(e.plast));
                chk("o_last", int'(o_last), int'(e.last));
                if (o_ready) begin
                    a.iw = int'(offw); a.id = int'(offd);
                    a.sh = o_sh; a.plast = o_plast; a.last = o_last;
                    logq.push_back(a);
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic start_job(input int p_w, input int p_d, input int n, input bit msb);
        gen(p_w, p_d, n, msb);
        logq.delete();
        @(posedge clk); #1;
        start = 1'b1; pw = 4'(p_w); pd = 4'(p_d); nrep = 16'(n); msb_first = msb;
        @(posedge clk); #1;
        start = 1'b0;
        pw = 4'($urandom); pd = 4'($urandom); nrep = 16'($urandom); msb_first = 1'($urandom);
        o_ready = 1'b1;
        chk("busy after start", int'(busy), 1);
        chk("valid after start", int'(o_valid), 1);
    endtask

    // mode 0: always ready; mode 1: ready toggles 1010...; poke: cycle to pulse start.
    task automatic run_job(input int mode, input int poke, output int busy_cnt, output int ncyc);
        bit seen = 0;
        int cyc = 0;
        busy_cnt = int'(busy);
        while (!seen && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            busy_cnt += int'(busy);
            if (cyc == poke) begin
                start = 1'b1; pw = 4'd3; pd = 4'd3; nrep = 16'd2;
            end else begin
                start = 1'b0;
            end
            o_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            if (done) seen = 1;
        end
        ncyc = cyc;
        start = 1'b0;
        if (!seen) begin
            chk("done timeout", 0, 1);
            return;
        end
        chk("valid in done", int'(o_valid), 0);
        chk("busy in done", int'(busy), 1);
        chk("scoreboard drained", expq.size(), 0);
        @(posedge clk); #1;
        busy_cnt += int'(busy);
        chk("busy after done", int'(busy), 0);
        chk("done one cycle", int'(done), 0);
    endtask

    int bc, nc, shc;
    int h1w[6] = '{0, 1, 0, 2, 1, 0};
    int h1d[6] = '{0, 0, 1, 0, 1, 2};
    int h1s[6] = '{1, 0, 1, 0, 0, 1};

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst valid", int'(o_valid), 0);
        chk("rst offw", int'(offw), 0);
        chk("rst offd", int'(offd), 0);
        chk("rst flags", int'({o_sh, o_plast, o_last}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 6x4 LSB-first
        start_job(6, 4, 1, 1'b0);
        run_job(0, 0, bc, nc);
        chk("6x4 lsb count", logq.size(), 24);
        chk("6x4 lsb length", nc, 24);
        for (int i = 0; i < 6 && i < logq.size(); i++) begin
            chk("6x4 lsb head iw", logq[i].iw, h1w[i]);
            chk("6x4 lsb head id", logq[i].id, h1d[i]);
            chk("6x4 lsb head sh", int'(logq[i].sh), h1s[i]);
        end
        shc = 0;
        foreach (logq[i]) shc += int'(logq[i].sh);
        chk("6x4 lsb sh count", shc, 9);
        if (logq.size() > 0) begin
            chk("6x4 lsb final iw", logq[logq.size()-1].iw, 5);
            chk("6x4 lsb final id", logq[logq.size()-1].id, 3);
            chk("6x4 lsb final flags", int'({logq[logq.size()-1].sh, logq[logq.size()-1].plast,
                                            logq[logq.size()-1].last}), 7);
        end

        // 6x4 MSB-first
        start_job(6, 4, 1, 1'b1);
        run_job(0, 0, bc, nc);
        chk("6x4 msb count", logq.size(), 24);
        if (logq.size() >= 3) begin
            chk("6x4 msb e0", logq[0].iw * 100 + logq[0].id * 10 + int'(logq[0].sh), 531);
            chk("6x4 msb e1", logq[1].iw * 100 + logq[1].id * 10 + int'(logq[1].sh), 520);
            chk("6x4 msb e2", logq[2].iw * 100 + logq[2].id * 10 + int'(logq[2].sh), 431);
            chk("6x4 msb last", logq[logq.size()-1].iw * 100 + logq[logq.size()-1].id * 10 +
                                int'(logq[logq.size()-1].last), 1);
        end

        // 1x1, three passes
        start_job(1, 1, 3, 1'b0);
        run_job(0, 0, bc, nc);
        chk("1x1 count", logq.size(), 3);
        chk("1x1 busy cycles", bc, 4);
        foreach (logq[i]) begin
            chk("1x1 sh/plast", int'({logq[i].sh, logq[i].plast}), 3);
            chk("1x1 last", int'(logq[i].last), (i == 2) ? 1 : 0);
        end

        // 3x2 with o_ready toggling
        start_job(3, 2, 1, 1'b0);
        run_job(1, 0, bc, nc);
        chk("3x2 stall count", logq.size(), 6);

        // pw=0 treated as 1; stray start mid-job
        start_job(0, 5, 1, 1'b0);
        run_job(0, 2, bc, nc);
        chk("0x5 count", logq.size(), 5);
        foreach (logq[i]) begin
            chk("0x5 iw", logq[i].iw, 0);
            chk("0x5 id", logq[i].id, i);
            chk("0x5 sh", int'(logq[i].sh), 1);
        end

        // nrep=0 treated as 1
        start_job(2, 2, 0, 1'b0);
        run_job(0, 0, bc, nc);
        chk("nrep0 count", logq.size(), 4);

        // Abort by reset after 7 elements
        start_job(4, 4, 1, 1'b0);
        for (int i = 0; i < 100 && logq.size() < 7; i++) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort accepted", logq.size(), 7);
        chk("abort valid", int'(o_valid), 0);
        chk("abort busy/done", int'({busy, done}), 0);
        chk("abort offsets", int'({offw, offd}), 0);
        chk("abort flags", int'({o_sh, o_plast, o_last}), 0);
        expq.delete();
        #20 rst_n = 1'b1;
        start_job(4, 4, 1, 1'b0);
        run_job(0, 0, bc, nc);
        chk("post-abort count", logq.size(), 16);
        if (logq.size() > 0)
            chk("post-abort first", logq[0].iw * 10 + logq[0].id, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
